// File: rtl/titan_pkg.sv
// titan_pkg: shared Wishbone constants and slave FSM state encoding
package titan_pkg;
  localparam int WB_SEL_W = 4;
  localparam int WB_DAT_W = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} wbs_state_e;
endpackage

// File: rtl/titan_bram_be.sv
// titan_bram_be: single-port byte-enabled synchronous RAM with one-cycle read
// ports: clk_i clock; we_i write enable; sel_i byte lanes; addr_i word index;
//        dat_i write data; dat_o registered read data (old contents on write)
module titan_bram_be
  import titan_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [WB_SEL_W-1:0] sel_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [WB_DAT_W-1:0] dat_i,
  output logic [WB_DAT_W-1:0] dat_o
);
  logic [WB_DAT_W-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < WB_SEL_W; b++)
      if (we_i && sel_i[b]) mem[addr_i][8*b+:8] <= dat_i[8*b+:8];
    dat_o <= mem[addr_i];
  end
endmodule

// File: rtl/titan_wb_slave_mem.sv
// titan_wb_slave_mem: Wishbone classic slave memory with wait states
// ports: clk_i clock; rst_i sync active-low reset; wbs_addr_i/dat_i/sel_i/we_i/
//        cyc_i/stb_i master request; wbs_dat_o read data; wbs_ack_o/err_o response
// macro TITAN_WBS_ADDR_ERR_EN: out-of-range accesses end with err instead of wrapping
module titan_wb_slave_mem
  import titan_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         wbs_addr_i,
  input  logic [WB_DAT_W-1:0] wbs_dat_i,
  input  logic [WB_SEL_W-1:0] wbs_sel_i,
  input  logic                wbs_we_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  output logic [WB_DAT_W-1:0] wbs_dat_o,
  output logic                wbs_ack_o,
  output logic                wbs_err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  wbs_state_e state_q;
  logic [3:0] cnt_q;
  logic ack_q, err_q, we_q;
  logic [31:0] addr_q;
  logic [WB_DAT_W-1:0] dat_q, rdata;
  logic [WB_SEL_W-1:0] sel_q;
  logic idle, req, to_resp, ok, we_d;
  logic [31:0] addr_d, off;
  logic [WB_DAT_W-1:0] dat_d;
  logic [WB_SEL_W-1:0] sel_d;
  logic [AW-1:0] idx;
  assign idle = state_q == ST_IDLE;
  assign req  = wbs_cyc_i & wbs_stb_i;
  // with zero wait states the RAM is driven straight from the bus, since the
  // commit/read edge is the same edge that latches the request
  assign addr_d = idle ? wbs_addr_i : addr_q;
  assign dat_d  = idle ? wbs_dat_i : dat_q;
  assign sel_d  = idle ? wbs_sel_i : sel_q;
  assign we_d   = idle ? wbs_we_i : we_q;
  assign off    = addr_d - BASE_ADDR;
  assign idx    = AW'(off >> 2);
`ifdef TITAN_WBS_ADDR_ERR_EN
  assign ok = (off >> 2) < 32'(DEPTH_WORDS);
`else
  assign ok = 1'b1;
`endif
  assign to_resp = idle ? (req && WAIT_CYCLES == 0)
                        : (state_q == ST_WAIT && wbs_cyc_i && cnt_q == 4'(WAIT_CYCLES));
  titan_bram_be #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk_i (clk_i),
    .we_i  (rst_i & to_resp & we_d & ok),
    .sel_i (sel_d),
    .addr_i(idx),
    .dat_i (dat_d),
    .dat_o (rdata)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= to_resp & ok;
      err_q <= to_resp & ~ok;
      case (state_q)
        ST_IDLE: if (req) begin
          addr_q  <= wbs_addr_i;
          dat_q   <= wbs_dat_i;
          sel_q   <= wbs_sel_i;
          we_q    <= wbs_we_i;
          state_q <= WAIT_CYCLES == 0 ? ST_RESP : ST_WAIT;
          cnt_q   <= WAIT_CYCLES == 0 ? 4'd0 : 4'd1;
        end
        ST_WAIT: begin
          state_q <= !wbs_cyc_i ? ST_IDLE : to_resp ? ST_RESP : ST_WAIT;
          cnt_q   <= (!wbs_cyc_i || to_resp) ? 4'd0 : cnt_q + 4'd1;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = ack_q ? rdata : '0;
endmodule

// File: tb/tb_titan_wb_slave_mem.sv
// tb_titan_wb_slave_mem: directed checks on a zero-wait and a three-wait instance
module tb_titan_wb_slave_mem;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [3:0]  sel [2];
  logic        we [2];
  logic        cyc [2];
  logic        stb [2];
  logic [31:0] dout [2];
  logic        ack [2];
  logic        err [2];
  logic [31:0] base [2];
  int ncmp = 0;
  int nfail = 0;
  titan_wb_slave_mem #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .wbs_addr_i(addr[0]), .wbs_dat_i(wdat[0]),
    .wbs_sel_i(sel[0]), .wbs_we_i(we[0]), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]),
    .wbs_dat_o(dout[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]));
  titan_wb_slave_mem #(.BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u3 (
    .clk_i(clk), .rst_i(rst[1]), .wbs_addr_i(addr[1]), .wbs_dat_i(wdat[1]),
    .wbs_sel_i(sel[1]), .wbs_we_i(we[1]), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]),
    .wbs_dat_o(dout[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cycle1();
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input int d, input logic w, input logic [31:0] off, input logic [31:0] wd,
                      input logic [3:0] s, input int el, input logic ee, input logic [31:0] erd,
                      input string tag);
    int lat = 0;
    logic a = 1'b0;
    logic e = 1'b0;
    logic [31:0] rd = '0;
    addr[d] = base[d] + off; wdat[d] = wd; sel[d] = s; we[d] = w; cyc[d] = 1'b1; stb[d] = 1'b1;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      cycle1();
      if (ack[d] | err[d]) begin lat = n; a = ack[d]; e = err[d]; rd = dout[d]; end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(el));
    chk({tag, " ack/err"}, {62'd0, a, e}, {62'd0, ~ee, ee});
    if (!w) chk({tag, " rdata"}, {32'd0, rd}, {32'd0, erd});
    cycle1();
    chk({tag, " one-pulse/idle dat"}, {30'd0, ack[d], err[d], dout[d]}, 64'd0);
  endtask
  initial begin
    logic [10:0] mask;
    logic seen;
    base[0] = 32'h0000_0000; base[1] = 32'h1000_0000;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; addr[d] = '0; wdat[d] = '0; sel[d] = '0; we[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0;
    end
    repeat (3) cycle1();
    chk("reset u0", {30'd0, ack[0], err[0], dout[0]}, 64'd0);
    chk("reset u3", {30'd0, ack[1], err[1], dout[1]}, 64'd0);
    rst[0] = 1'b1; rst[1] = 1'b1;
    cycle1();
    xfer(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 0, 0, "w0 deadbeef");
    xfer(0, 0, 32'h10, 0, 4'h1, 1, 0, 32'hDEAD_BEEF, "r0 deadbeef");
    xfer(0, 1, 32'h20, 32'h1122_3344, 4'hF, 1, 0, 0, "w0 11223344");
    xfer(0, 1, 32'h22, 32'hAABB_CCDD, 4'b0101, 1, 0, 0, "w0 lanes 0101");
    xfer(0, 0, 32'h20, 0, 4'hF, 1, 0, 32'h11BB_33DD, "r0 merged");
    xfer(0, 1, 32'h20, 32'hFFFF_FFFF, 4'h0, 1, 0, 0, "w0 sel0");
    xfer(0, 0, 32'h20, 0, 4'hF, 1, 0, 32'h11BB_33DD, "r0 after sel0");
    xfer(0, 1, 32'h0, 32'hCAFE_F00D, 4'hF, 1, 0, 0, "w0 word0");
`ifdef TITAN_WBS_ADDR_ERR_EN
    xfer(0, 1, 32'h1000, 32'h1234_5678, 4'hF, 1, 1, 0, "w0 out of range");
    xfer(0, 0, 32'h1000, 0, 4'hF, 1, 1, 0, "r0 out of range");
    xfer(0, 0, 32'h0, 0, 4'hF, 1, 0, 32'hCAFE_F00D, "r0 word0 intact");
`else
    xfer(0, 1, 32'h1000, 32'h1234_5678, 4'hF, 1, 0, 0, "w0 alias");
    xfer(0, 0, 32'h0, 0, 4'hF, 1, 0, 32'h1234_5678, "r0 word0 aliased");
    xfer(0, 0, 32'h1000, 0, 4'hF, 1, 0, 32'h1234_5678, "r0 alias read");
`endif
    xfer(1, 1, 32'h40, 32'h0000_0055, 4'hF, 4, 0, 0, "w3 0x55");
    xfer(1, 0, 32'h40, 0, 4'hF, 4, 0, 32'h0000_0055, "r3 0x55");
    addr[1] = base[1] + 32'h40; we[1] = 1'b0; sel[1] = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
    mask = '0;
    for (int c = 1; c <= 9; c++) begin
      cycle1();
      mask[c] = ack[1];
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    cycle1();
    mask[10] = ack[1];
    chk("r3 held stb ack cycles", {53'd0, mask}, 64'h210);
    addr[1] = base[1] + 32'h40; wdat[1] = 32'h0000_0099; we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
    cycle1();
    cycle1();
    cyc[1] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle1();
      seen |= ack[1] | err[1];
    end
    stb[1] = 1'b0;
    chk("w3 abort no response", {63'd0, seen}, 64'd0);
    xfer(1, 0, 32'h40, 0, 4'hF, 4, 0, 32'h0000_0055, "r3 after abort");
    addr[1] = base[1] + 32'h40; wdat[1] = 32'h0000_0077; we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
    cycle1();
    rst[1] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle1();
      seen |= ack[1] | err[1];
    end
    chk("w3 reset in wait no response", {63'd0, seen}, 64'd0);
    rst[1] = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
    cycle1();
    xfer(1, 0, 32'h40, 0, 4'hF, 4, 0, 32'h0000_0055, "r3 after reset");
    xfer(0, 0, 32'h10, 0, 4'hF, 1, 0, 32'hDEAD_BEEF, "r0 final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
